alu_control_sequencer: RTL and testbench
========================================

Name: alu_control_sequencer

Overview:
- Hardware control unit that generates, cycle by cycle, the datapath control strobes the phase-1 benches currently drive by hand.
- Sequences fetch (T0–T2) and execute (T3–T6) for register-register ALU instructions, including MUL/DIV writing HI/LO.
- Sits beside `datapath` and drives its control inputs directly.
- Reads the instruction through the `ir` input.

Parameters:
- NUM_REGS, 16, number of general registers; width of Rin/Rout one-hot vectors.
- OPW, 5, opcode width; ALU opcode field width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins execution from IDLE.
- mem_ready  in  1  memory has valid Mdatain; qualifies T1.
- ir  in  32  IR register contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- Rout  out  NUM_REGS  one-hot register-to-bus enable.
- Rin  out  NUM_REGS  one-hot register load enable.
- opcode  out  OPW  ALU operation select.
- run  out  1  high while sequencing.
- illegal  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- Reset (clear=0, async):
  - state=IDLE, run=0.
  - All strobes, Rin, Rout and illegal are 0.
  - opcode=NOP (11010).
- Outputs are Moore-decoded from the state register and the current `ir`.
- Every strobe is asserted for exactly the full cycle(s) spent in its state.
- IDLE:
  - start=1 → T0, run←1.
  - start while run=1 is ignored.
- T0: PCout, MARin, incPC, Zin; opcode=ADD. → T1.
- T1: ZLowOut, PCin, read, MDRin.
  - Stay in T1 while mem_ready=0.
  - PCin is asserted only in the cycle mem_ready=1, so PC loads once.
  - → T2 on mem_ready=1.
- T2: MDRout, IRin. → T3.
- T3: decode `ir` opcode (IR loaded at end of T2).
  - Supported opcode: Rout[Rb], Yin. → T4.
  - Unsupported opcode: no strobes, illegal=1 for this cycle. → T0.
- T4: Zin, opcode=ir opcode.
  - Rout[Rc] for two-operand ops.
  - Rout[Rb] for NEG/NOT.
  - → T5.
- T5: ZLowOut.
  - Rin[Ra] for ALU ops. → T0.
  - LOin for MUL/DIV. → T6.
- T6 (MUL/DIV only): ZHighOut, HIin. → T0.
- Cycle counts with mem_ready tied high:
  - ALU instruction: 6 cycles.
  - MUL/DIV: 7 cycles.
  - Each mem_ready=0 cycle adds one.
- Register-index decode: a 4-bit field indexes one-hot bit; exactly one Rin/Rout bit set when asserted. Ra=Rb=Rc is legal.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. Partially executed instruction is abandoned.
- Opcode encodings:
  - ADD 00011, SUB 00100, AND 00101, OR 00110
  - ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011
  - MUL 01111, DIV 10000, NEG 10001, NOT 10010
  - NOP 11010 (NOP executes T3 as no-op then → T0; not illegal)

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds input `step` (1 bit).
  - On completion of an instruction, the FSM enters HOLD instead of T0, with run=0.
  - step pulse → T0, run=1.
  - Illegal-opcode abort also goes to HOLD.
- Undefined: no `step` port, no HOLD state; instructions chain continuously.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - State enum: IDLE, T0–T6, HOLD.
  - Opcode constants listed above.
  - IR field bit-position constants.
- Sub-module `reg_select_decoder`: 4-bit index plus enable → NUM_REGS one-hot vector; instantiated for Rin and Rout.

Test Plan:
- SHRA, ir=opcode 01010, Ra=4, Rb=3, Rc=7, mem_ready=1, start pulse → strobes as follows, then back to T0 with illegal=0:
  - T3: Rout=0x0008, Yin.
  - T4: Rout=0x0080, opcode=01010, Zin.
  - T5: ZLowOut, Rin=0x0010.
- MUL, Rb=2, Rc=5 → T5 LOin=1 with Rin=0; T6 ZHighOut+HIin; 7 cycles total.
- mem_ready held 0 for 3 cycles in T1 → read/MDRin high 4 cycles, PCin high exactly 1 cycle; total 9 cycles.
- Opcode 11111 → illegal high 1 cycle at T3, no Rin/Zin; next state T0.
- clear driven low during T4 → outputs 0 asynchronously before the next edge; state IDLE; start needed to resume.
- SINGLE_STEP_EN: after ADD completes → run=0, no T0 until step; step pulse → T0 next cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the hardwired ALU control sequencer.
// Holds the sequencer state encoding, the ALU opcode constants, the bit
// positions of the instruction fields inside IR, and opcode class helpers.
package cpu_ctrl_pkg;

  // Sequencer states: fetch is T0..T2, execute is T3..T6.
  // HOLD is only reachable when the single-step build option is enabled.
  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    HOLD
  } state_t;

  // Field widths inside the 32-bit instruction word.
  localparam int OP_FIELD_W = 5;
  localparam int REG_IDX_W  = 4;

  // Least-significant bit of each instruction field.
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  // ALU opcode encodings.
  localparam logic [OP_FIELD_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_FIELD_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_FIELD_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_FIELD_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_FIELD_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_FIELD_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_FIELD_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_FIELD_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_FIELD_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_FIELD_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_FIELD_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_FIELD_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_FIELD_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_FIELD_W-1:0] OP_NOP  = 5'b11010;

  // MUL and DIV produce a 64-bit result and need the extra HI write cycle.
  function automatic logic is_muldiv(input logic [OP_FIELD_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // NEG and NOT read only Rb, so Rb is driven again in T4.
  function automatic logic is_unary(input logic [OP_FIELD_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Ops that read Rb then Rc; the shift/logic/arith block is contiguous.
  function automatic logic is_two_operand(input logic [OP_FIELD_W-1:0] op);
    return ((op >= OP_ADD) && (op <= OP_SHL)) || is_muldiv(op);
  endfunction

  // Anything that proceeds past decode into T4.
  function automatic logic is_executable(input logic [OP_FIELD_W-1:0] op);
    return is_two_operand(op) || is_unary(op);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: turns a register index plus enable into a one-hot
// register select vector. The output is all zero while disabled, so at
// most one register ever sees its load or bus-drive strobe.
module reg_select_decoder #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot
);

  // Compare the index against every register number to form the one-hot bit.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_onehot[i] = i_en && (i_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hardwired control unit that walks the datapath
// through instruction fetch (T0..T2) and register-register execute
// (T3..T6), including the two-cycle HI/LO writeback of MUL and DIV.
// Strobes are decoded from the state register and the live IR contents;
// PCin additionally looks at mem_ready so the PC is loaded exactly once.
// Optional build macro SINGLE_STEP_EN: adds a `step` input and parks the
// sequencer in HOLD (run low) after every instruction until step pulses.
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                MARin,
  output logic                incPC,
  output logic                Zin,
  output logic                ZLowOut,
  output logic                ZHighOut,
  output logic                PCin,
  output logic                read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [OPW-1:0]      opcode,
  output logic                run,
  output logic                illegal
);

  // Where a finished (or aborted) instruction goes next.
`ifdef SINGLE_STEP_EN
  localparam state_t DONE_STATE = HOLD;
`else
  localparam state_t DONE_STATE = T0;
`endif

  state_t                r_state;
  state_t                w_nextState;

  logic [OP_FIELD_W-1:0] w_irOp;
  logic [REG_IDX_W-1:0]  w_ra;
  logic [REG_IDX_W-1:0]  w_rb;
  logic [REG_IDX_W-1:0]  w_rc;
  logic                  w_unusedIr;

  logic                  w_rinEn;
  logic                  w_routEn;
  logic [REG_IDX_W-1:0]  w_routIdx;

  assign w_irOp     = ir[IR_OP_LSB +: OP_FIELD_W];
  assign w_ra       = ir[IR_RA_LSB +: REG_IDX_W];
  assign w_rb       = ir[IR_RB_LSB +: REG_IDX_W];
  assign w_rc       = ir[IR_RC_LSB +: REG_IDX_W];
  assign w_unusedIr = ^ir[IR_RC_LSB-1:0];

  // run tracks whether an instruction is in flight; idle and held are not.
  assign run = (r_state != IDLE) && (r_state != HOLD);

  // State register; clear drops straight back to IDLE, abandoning the instruction.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and strobe decode for the current step of the instruction.
  always_comb begin
    w_nextState = r_state;
    PCout       = 1'b0;
    MARin       = 1'b0;
    incPC       = 1'b0;
    Zin         = 1'b0;
    ZLowOut     = 1'b0;
    ZHighOut    = 1'b0;
    PCin        = 1'b0;
    read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    illegal     = 1'b0;
    opcode      = OPW'(OP_NOP);
    w_rinEn     = 1'b0;
    w_routEn    = 1'b0;
    w_routIdx   = w_rb;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = T0;
        end
      end

      // Send PC to MAR and compute PC+1 into Z.
      T0: begin
        PCout       = 1'b1;
        MARin       = 1'b1;
        incPC       = 1'b1;
        Zin         = 1'b1;
        opcode      = OPW'(OP_ADD);
        w_nextState = T1;
      end

      // Wait for memory; PC+1 is written back only in the completing cycle.
      T1: begin
        ZLowOut = 1'b1;
        read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) begin
          PCin        = 1'b1;
          w_nextState = T2;
        end
      end

      T2: begin
        MDRout      = 1'b1;
        IRin        = 1'b1;
        w_nextState = T3;
      end

      // Decode: first operand into Y, NOP retires quietly, anything else aborts.
      T3: begin
        if (is_executable(w_irOp)) begin
          w_routEn    = 1'b1;
          w_routIdx   = w_rb;
          Yin         = 1'b1;
          w_nextState = T4;
        end else if (w_irOp == OP_NOP) begin
          w_nextState = DONE_STATE;
        end else begin
          illegal     = 1'b1;
          w_nextState = DONE_STATE;
        end
      end

      // Second operand onto the bus with the ALU operation selected.
      T4: begin
        Zin         = 1'b1;
        opcode      = OPW'(w_irOp);
        w_routEn    = 1'b1;
        w_routIdx   = is_unary(w_irOp) ? w_rb : w_rc;
        w_nextState = T5;
      end

      // Low result word goes to Ra, or to LO for the wide ops.
      T5: begin
        ZLowOut = 1'b1;
        if (is_muldiv(w_irOp)) begin
          LOin        = 1'b1;
          w_nextState = T6;
        end else begin
          w_rinEn     = 1'b1;
          w_nextState = DONE_STATE;
        end
      end

      T6: begin
        ZHighOut    = 1'b1;
        HIin        = 1'b1;
        w_nextState = DONE_STATE;
      end

      HOLD: begin
`ifdef SINGLE_STEP_EN
        if (step) begin
          w_nextState = T0;
        end
`else
        w_nextState = IDLE;
`endif
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  reg_select_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (REG_IDX_W)
  ) u_rinDecoder (
    .i_idx    (w_ra),
    .i_en     (w_rinEn),
    .o_onehot (Rin)
  );

  reg_select_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (REG_IDX_W)
  ) u_routDecoder (
    .i_idx    (w_routIdx),
    .i_en     (w_routEn),
    .o_onehot (Rout)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: self-checking bench for alu_control_sequencer.
// Expected strobe timelines are generated per instruction from the
// fetch/execute rules; a vector table adds hand-derived cycle counts.
module tb_alu_control_sequencer;

  localparam logic [4:0] ADD  = 5'b00011;
  localparam logic [4:0] SHRA = 5'b01010;
  localparam logic [4:0] MUL  = 5'b01111;
  localparam logic [4:0] DIV  = 5'b10000;
  localparam logic [4:0] NEG  = 5'b10001;
  localparam logic [4:0] NOTOP = 5'b10010;
  localparam logic [4:0] NOP  = 5'b11010;

  localparam int KIND_BINARY  = 0;
  localparam int KIND_UNARY   = 1;
  localparam int KIND_WIDE    = 2;
  localparam int KIND_NOP     = 3;
  localparam int KIND_ILLEGAL = 4;

  typedef struct packed {
    logic        run;
    logic        illegal;
    logic        PCout;
    logic        MARin;
    logic        incPC;
    logic        Zin;
    logic        ZLowOut;
    logic        ZHighOut;
    logic        PCin;
    logic        read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        HIin;
    logic        LOin;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [4:0]  opcode;
  } outs_t;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    int          waits;
    int          expCycles;
    logic [15:0] expRin;
    int          expIllegal;
    int          expRead;
  } vec_t;

  logic        clock;
  logic        clear;
  logic        start;
  logic        mem_ready;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif
  logic [31:0] ir;
  logic        PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin;
  logic        read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic [4:0]  opcode;
  logic        run;
  logic        illegal;

  int          checks = 0;
  int          errors = 0;
  outs_t       timeline[$];
  vec_t        vecs[9];
  logic [4:0]  validOps[14];

  alu_control_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .mem_ready (mem_ready),
`ifdef SINGLE_STEP_EN
    .step      (step),
`endif
    .ir        (ir),
    .PCout     (PCout),
    .MARin     (MARin),
    .incPC     (incPC),
    .Zin       (Zin),
    .ZLowOut   (ZLowOut),
    .ZHighOut  (ZHighOut),
    .PCin      (PCin),
    .read      (read),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .HIin      (HIin),
    .LOin      (LOin),
    .Rout      (Rout),
    .Rin       (Rin),
    .opcode    (opcode),
    .run       (run),
    .illegal   (illegal)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic outs_t idleOuts();
    outs_t o;
    o = '0;
    o.opcode = NOP;
    return o;
  endfunction

  function automatic outs_t blankOuts();
    outs_t o;
    o = idleOuts();
    o.run = 1'b1;
    return o;
  endfunction

  function automatic outs_t sampleDut();
    outs_t o;
    o = '{run, illegal, PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin,
          read, MDRin, MDRout, IRin, Yin, HIin, LOin, Rout, Rin, opcode};
    return o;
  endfunction

  function automatic int classify(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return KIND_BINARY;
    if (op == MUL || op == DIV) return KIND_WIDE;
    if (op == NEG || op == NOTOP) return KIND_UNARY;
    if (op == NOP) return KIND_NOP;
    return KIND_ILLEGAL;
  endfunction

  // Expected per-cycle outputs of one instruction, from fetch through writeback.
  function automatic void buildTimeline(input logic [31:0] irv, input int waits);
    outs_t      o;
    logic [4:0] op;
    int         kind;
    op   = irv[31:27];
    kind = classify(op);
    timeline.delete();
    o = blankOuts(); o.PCout = 1; o.MARin = 1; o.incPC = 1; o.Zin = 1; o.opcode = ADD;
    timeline.push_back(o);
    for (int w = 0; w < waits; w++) begin
      o = blankOuts(); o.ZLowOut = 1; o.read = 1; o.MDRin = 1;
      timeline.push_back(o);
    end
    o = blankOuts(); o.ZLowOut = 1; o.read = 1; o.MDRin = 1; o.PCin = 1;
    timeline.push_back(o);
    o = blankOuts(); o.MDRout = 1; o.IRin = 1;
    timeline.push_back(o);
    if (kind == KIND_ILLEGAL) begin
      o = blankOuts(); o.illegal = 1;
      timeline.push_back(o);
      return;
    end
    if (kind == KIND_NOP) begin
      timeline.push_back(blankOuts());
      return;
    end
    o = blankOuts(); o.Yin = 1; o.Rout = 16'h1 << irv[22:19];
    timeline.push_back(o);
    o = blankOuts(); o.Zin = 1; o.opcode = op;
    o.Rout = 16'h1 << ((kind == KIND_UNARY) ? irv[22:19] : irv[18:15]);
    timeline.push_back(o);
    if (kind == KIND_WIDE) begin
      o = blankOuts(); o.ZLowOut = 1; o.LOin = 1;
      timeline.push_back(o);
      o = blankOuts(); o.ZHighOut = 1; o.HIin = 1;
      timeline.push_back(o);
    end else begin
      o = blankOuts(); o.ZLowOut = 1; o.Rin = 16'h1 << irv[26:23];
      timeline.push_back(o);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs for cycle k of an instruction: IR loads after T2, memory stalls in T1.
  task automatic applyStimulus(input int k, input int waits, input logic [31:0] irv);
    if (k == 0) ir = $urandom;
    if (k == waits + 3) ir = irv;
    if (k >= 1 && k <= waits) mem_ready = 1'b0;
    else if (k == waits + 1) mem_ready = 1'b1;
    else mem_ready = 1'($urandom);
    start = 1'($urandom);
  endtask

  task automatic startRun();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Run one instruction starting at T0, checking every cycle; returns observed stats.
  task automatic runInstr(input logic [31:0] irv, input int waits, output int cyc,
                          output logic [15:0] rinSeen, output int illCnt,
                          output int pcinCnt, output int readCnt);
    outs_t act;
    int    len;
    buildTimeline(irv, waits);
    len     = timeline.size();
    cyc     = len + 1;
    rinSeen = '0;
    illCnt  = 0;
    pcinCnt = 0;
    readCnt = 0;
    for (int k = 0; k < len; k++) begin
      applyStimulus(k, waits, irv);
      @(negedge clock);
      act = sampleDut();
      checkOutput($sformatf("op%02b cycle%0d", irv[31:27], k), 64'(act), 64'(timeline[k]));
      if (k >= 1 && cyc > len && ((act.PCout && act.MARin) || !act.run)) cyc = k;
      rinSeen |= act.Rin;
      illCnt  += int'(act.illegal);
      pcinCnt += int'(act.PCin);
      readCnt += int'(act.read);
      @(posedge clock); #1;
    end
    start = 1'b0;
    act = sampleDut();
    if (cyc > len && ((act.PCout && act.MARin) || !act.run)) cyc = len;
`ifdef SINGLE_STEP_EN
    for (int h = 0; h < 2; h++) begin
      @(negedge clock);
      checkOutput("hold", 64'(sampleDut()), 64'(idleOuts()));
      @(posedge clock); #1;
    end
    step = 1'b1;
    @(posedge clock); #1;
    step = 1'b0;
`endif
  endtask

  initial begin
    logic [31:0] irv;
    logic [15:0] rinSeen;
    int          cyc, illCnt, pcinCnt, readCnt, waits;
    logic [4:0]  op;
    outs_t       t0Pattern;

    validOps = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11010};
    vecs[0] = '{SHRA,     4'd4,  4'd3,  4'd7,  0, 6, 16'h0010, 0, 1};
    vecs[1] = '{MUL,      4'd1,  4'd2,  4'd5,  0, 7, 16'h0000, 0, 1};
    vecs[2] = '{ADD,      4'd2,  4'd2,  4'd2,  3, 9, 16'h0004, 0, 4};
    vecs[3] = '{5'b11111, 4'd6,  4'd1,  4'd2,  0, 4, 16'h0000, 1, 1};
    vecs[4] = '{NOP,      4'd3,  4'd3,  4'd3,  1, 5, 16'h0000, 0, 2};
    vecs[5] = '{NEG,      4'd15, 4'd9,  4'd0,  0, 6, 16'h8000, 0, 1};
    vecs[6] = '{DIV,      4'd0,  4'd14, 4'd13, 2, 9, 16'h0000, 0, 3};
    vecs[7] = '{NOTOP,    4'd0,  4'd5,  4'd6,  0, 6, 16'h0001, 0, 1};
    vecs[8] = '{5'b00000, 4'd7,  4'd7,  4'd7,  0, 4, 16'h0000, 1, 1};

    clear     = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
`ifdef SINGLE_STEP_EN
    step      = 1'b0;
`endif
    ir        = '0;

    #12;
    checkOutput("reset outputs", 64'(sampleDut()), 64'(idleOuts()));
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    checkOutput("idle after reset", 64'(sampleDut()), 64'(idleOuts()));
    startRun();

    for (int i = 0; i < 9; i++) begin
      irv = {vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, 15'($urandom)};
      runInstr(irv, vecs[i].waits, cyc, rinSeen, illCnt, pcinCnt, readCnt);
      checkOutput($sformatf("vec%0d cycles", i), 64'(cyc), 64'(vecs[i].expCycles));
      checkOutput($sformatf("vec%0d Rin", i), 64'(rinSeen), 64'(vecs[i].expRin));
      checkOutput($sformatf("vec%0d illegal", i), 64'(illCnt), 64'(vecs[i].expIllegal));
      checkOutput($sformatf("vec%0d PCin", i), 64'(pcinCnt), 64'(1));
      checkOutput($sformatf("vec%0d read", i), 64'(readCnt), 64'(vecs[i].expRead));
    end

    for (int n = 0; n < 60; n++) begin
      op    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : validOps[$urandom_range(0, 13)];
      irv   = {op, 27'($urandom)};
      waits = $urandom_range(0, 3);
      runInstr(irv, waits, cyc, rinSeen, illCnt, pcinCnt, readCnt);
      checkOutput($sformatf("rand%0d cycles", n), 64'(cyc), 64'(timeline.size()));
      checkOutput($sformatf("rand%0d PCin", n), 64'(pcinCnt), 64'(1));
      checkOutput($sformatf("rand%0d read", n), 64'(readCnt), 64'(waits + 1));
      checkOutput($sformatf("rand%0d onehot", n), 64'($countones(rinSeen) <= 1), 64'(1));
      checkOutput($sformatf("rand%0d illegal", n), 64'(illCnt <= 1), 64'(1));
    end

    // Abort an ADD in T4 with an asynchronous clear, then resume with start.
    ir        = {ADD, 4'd1, 4'd2, 4'd3, 15'd0};
    mem_ready = 1'b1;
    start     = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    checkOutput("T4 before clear", 64'(Zin), 64'(1));
    #2 clear = 1'b0;
    #1;
    checkOutput("async clear", 64'(sampleDut()), 64'(idleOuts()));
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("idle wait%0d", c), 64'(sampleDut()), 64'(idleOuts()));
    end
    buildTimeline(ir, 0);
    t0Pattern = timeline[0];
    startRun();
    checkOutput("resume T0", 64'(sampleDut()), 64'(t0Pattern));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit in case the sequencing ever stalls the bench.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, want finish before 200000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
